id_branch_hazard_ctrl: RTL and testbench

ID_BRANCH_HAZARD_CTRL -- requirements
Module: id_branch_hazard_ctrl

---
 rtl/id_branch_hazard_ctrl_pkg.sv | 19 +
 rtl/sat_counter.sv | 31 +++
 rtl/id_branch_hazard_ctrl.sv | 88 ++++++++
 tb/tb_id_branch_hazard_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/id_branch_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the ID-stage branch hazard controller:
// FSM state encoding, the hard-wired zero register, and the producer-hit rule.
package id_branch_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    HOLD1 = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // r0 is hard-wired, so a write to it never satisfies a consumer.
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] wr,
                                   input logic [4:0] r);
    return we & (wr == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_branch_hazard_ctrl.sv
// ID-stage branch operand hazard control: WB producers are forwarded to the
// comparator, EX producers cost two stall cycles, MEM producers cost one.
module id_branch_hazard_ctrl
  import id_branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Branch_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       Write_Reg_EX,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       Write_Reg_MEM,
  input  logic             RegWrite_WB,
  input  logic [4:0]       Write_Reg_WB,
  output logic             Forward_C_ID,
  output logic             Forward_D_ID,
  output logic             Stall_ID,
  output logic             Bubble_EX,
  output logic [CNT_W-1:0] Branch_Stall_Cnt
);

  hz_state_e state_q;
  hz_state_e state_d;
  logic      ex_we;
  logic      ex_hit;
  logic      mem_hit;
  logic      stall;

  // A load is only a producer when it also writes the register file, so it
  // reduces to the plain RegWrite_EX case.
  assign ex_we = RegWrite_EX | (MemRead_EX & RegWrite_EX);

  assign Forward_C_ID = Branch_ID & reg_hit(RegWrite_WB, Write_Reg_WB, Rs_ID);
  assign Forward_D_ID = Branch_ID & reg_hit(RegWrite_WB, Write_Reg_WB, Rt_ID);

  always_comb begin
    ex_hit  = Branch_ID & (reg_hit(ex_we, Write_Reg_EX, Rs_ID) |
                           reg_hit(ex_we, Write_Reg_EX, Rt_ID));
    mem_hit = Branch_ID & (reg_hit(RegWrite_MEM, Write_Reg_MEM, Rs_ID) |
                           reg_hit(RegWrite_MEM, Write_Reg_MEM, Rt_ID));
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        // EX dominates: its result is two stages from WB, covering any MEM hit.
        if (ex_hit) begin
          stall   = 1'b1;
          state_d = HOLD1;
        end else if (mem_hit) begin
          stall   = 1'b1;
        end
      end
      HOLD1: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign Stall_ID  = stall;
  assign Bubble_EX = stall;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall),
    .count(Branch_Stall_Cnt)
  );

endmodule

// File: tb/tb_id_branch_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor
// pops and compares; a 16-bit and a 2-bit counter instance share inputs.
module tb_id_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Branch_ID = 1'b0;
  logic [4:0] Rs_ID = 5'd0, Rt_ID = 5'd0;
  logic       RegWrite_EX = 1'b0, MemRead_EX = 1'b0;
  logic [4:0] Write_Reg_EX = 5'd0;
  logic       RegWrite_MEM = 1'b0;
  logic [4:0] Write_Reg_MEM = 5'd0;
  logic       RegWrite_WB = 1'b0;
  logic [4:0] Write_Reg_WB = 5'd0;

  logic        fc_a, fd_a, st_a, bb_a;
  logic [15:0] cnt_a;
  logic        fc_b, fd_b, st_b, bb_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  id_branch_hazard_ctrl #(.CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .Branch_ID(Branch_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Write_Reg_EX(Write_Reg_EX),
    .RegWrite_MEM(RegWrite_MEM), .Write_Reg_MEM(Write_Reg_MEM),
    .RegWrite_WB(RegWrite_WB), .Write_Reg_WB(Write_Reg_WB),
    .Forward_C_ID(fc_a), .Forward_D_ID(fd_a), .Stall_ID(st_a), .Bubble_EX(bb_a),
    .Branch_Stall_Cnt(cnt_a)
  );

  id_branch_hazard_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .Branch_ID(Branch_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Write_Reg_EX(Write_Reg_EX),
    .RegWrite_MEM(RegWrite_MEM), .Write_Reg_MEM(Write_Reg_MEM),
    .RegWrite_WB(RegWrite_WB), .Write_Reg_WB(Write_Reg_WB),
    .Forward_C_ID(fc_b), .Forward_D_ID(fd_b), .Stall_ID(st_b), .Bubble_EX(bb_b),
    .Branch_Stall_Cnt(cnt_b)
  );

  typedef struct {
    string tag;
    bit    fc, fd, st;
    int    c16, c2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: forced stall cycles still owed, and counter values.
  int owed = 0;
  int m16 = 0;
  int m2 = 0;

  function automatic bit hits(input logic we, input logic [4:0] wr, input logic [4:0] r);
    return we && (wr == r) && (r != 5'd0);
  endfunction

  task automatic chk(input string name, input string tag, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s [%s] actual=%0d required=%0d at %0t", name, tag, act, req, $time);
    end
  endtask

  task automatic step(input string tag, input logic rst_v, input logic br,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic rwe, input logic mre, input logic [4:0] wre,
                      input logic rwm, input logic [4:0] wrm,
                      input logic rww, input logic [4:0] wrw);
    exp_t e;
    bit exh, memh;
    @(posedge clk);
    #1;
    reset = rst_v; Branch_ID = br; Rs_ID = rs; Rt_ID = rt;
    RegWrite_EX = rwe; MemRead_EX = mre; Write_Reg_EX = wre;
    RegWrite_MEM = rwm; Write_Reg_MEM = wrm;
    RegWrite_WB = rww; Write_Reg_WB = wrw;
    if (rst_v) begin
      owed = 0; m16 = 0; m2 = 0;
    end
    exh  = br && (hits(rwe, wre, rs) || hits(rwe, wre, rt));
    memh = br && (hits(rwm, wrm, rs) || hits(rwm, wrm, rt));
    e.tag = tag;
    e.st  = (owed > 0) || exh || memh;
    e.fc  = br && hits(rww, wrw, rs);
    e.fd  = br && hits(rww, wrw, rt);
    e.c16 = m16;
    e.c2  = m2;
    q.push_back(e);
    if (!rst_v) begin
      if (e.st) begin
        m16 = (m16 < 65535) ? m16 + 1 : m16;
        m2  = (m2 < 3) ? m2 + 1 : m2;
      end
      owed = (owed == 0 && exh) ? 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fwd_c",   e.tag, int'(fc_a),  int'(e.fc));
      chk("fwd_d",   e.tag, int'(fd_a),  int'(e.fd));
      chk("stall",   e.tag, int'(st_a),  int'(e.st));
      chk("bubble",  e.tag, int'(bb_a),  int'(e.st));
      chk("cnt16",   e.tag, int'(cnt_a), e.c16);
      chk("stall_w2", e.tag, int'(st_b), int'(e.st));
      chk("fwd_w2",  e.tag, int'({fc_b, fd_b, bb_b}), int'({e.fc, e.fd, e.st}));
      chk("cnt2",    e.tag, int'(cnt_b), e.c2);
    end
  end

  initial begin
    // reset state
    step("reset0", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step("reset1", 1'b1, 1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
    // EX producer on Rs: two stalls, then WB forward
    step("ex_c0", 1'b0, 1'b1, 5'd8, 5'd1, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
    step("ex_c1", 1'b0, 1'b1, 5'd8, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0);
    step("ex_c2", 1'b0, 1'b1, 5'd8, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
    // MEM producer on Rt: one stall, then forward D
    step("mem_c0", 1'b0, 1'b1, 5'd2, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0);
    step("mem_c1", 1'b0, 1'b1, 5'd2, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    // r0 never hits
    step("r0", 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    // no branch: hits ignored
    step("nobr", 1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7);
    // EX on Rs plus MEM on Rt: exactly two stalls, load producer
    step("exm_c0", 1'b0, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0);
    step("exm_c1", 1'b0, 1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd6);
    step("exm_c2", 1'b0, 1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    // reset asserted while in HOLD1
    step("rh_c0", 1'b0, 1'b1, 5'd10, 5'd11, 1'b1, 1'b0, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rh_rst", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rh_post", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    // four EX-hit branches back to back: 2-bit counter saturates
    for (int i = 0; i < 4; i++) begin
      step("sat_ex", 1'b0, 1'b1, 5'd12, 5'd13, 1'b1, 1'b0, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0);
      step("sat_hold", 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 5'd12, 1'b0, 5'd0);
    end
    step("sat_idle", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    // randomized traffic over a small register range so hits are frequent
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
